fetch_decode: RTL and testbench

Instruction fetch and decode stage of the 16-bit CPU, directly upstream of the addressing-mode stage. Fetches instruction words from unified memory over a req/ack handshake and reads source registers from the register file. For two-word instructions (MVI, LDA) it fetches the trailing word, and for LDA the memory operand. It then presents one fully assembled operand bundle per instruction to the addressing-mode stage through a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/fd_pc_reg.sv | 34 +++
 rtl/fetch_decode.sv | 163 ++++++++++++++++
 tb/tb_fetch_decode.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared opcode constants, instruction field positions and the
//            fetch/decode state encoding for the 16-bit CPU pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_MVI = 4'b1100;
  localparam logic [3:0] OP_LDA = 4'b1101;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;

  typedef enum logic [2:0] {
    FD_FETCH  = 3'd0,
    FD_DECODE = 3'd1,
    FD_IMM    = 3'd2,
    FD_OPND   = 3'd3,
    FD_ISSUE  = 3'd4
  } fd_state_t;

  // MVI and LDA carry a trailing word (immediate or operand address).
  function automatic logic is_two_word(input logic [3:0] opc);
    return (opc == OP_MVI) || (opc == OP_LDA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fd_pc_reg.sv
// ============================================================================
// Module   : fd_pc_reg
// Purpose  : Program counter with async reset and a modulo-2^16 increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fd_pc_reg
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  output logic [WORD_W-1:0] o_pc
);

  logic [WORD_W-1:0] r_pc;

  // Natural 16-bit overflow gives the FFFF -> 0000 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_inc) begin
      r_pc <= r_pc + {{(WORD_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_decode.sv
// ============================================================================
// Module   : fetch_decode
// Purpose  : Instruction fetch/decode stage; assembles one operand bundle per
//            instruction for the addressing-mode stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_decode
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        rf_raddr1,
  output logic [2:0]        rf_raddr2,
  input  logic [WORD_W-1:0] rf_rdata1,
  input  logic [WORD_W-1:0] rf_rdata2,
  output logic [WORD_W-1:0] op1_data,
  output logic [WORD_W-1:0] op2_data,
  output logic [WORD_W-1:0] op1_regaddr,
  output logic [WORD_W-1:0] op2_regaddr,
  output logic [3:0]        am_opcode,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [WORD_W-1:0] pc
);

  fd_state_t               r_state;
  fd_state_t               w_next;
  logic [OPC_MSB:RS_LSB]   r_ir;
  logic [WORD_W-1:0]       r_imm;
  logic [WORD_W-1:0]       r_ldata;
  logic [WORD_W-1:0]       r_rd1;
  logic [WORD_W-1:0]       r_rd2;
  logic                    w_req;
  logic                    w_pc_inc;
  logic [3:0]              w_opc;
  logic [WORD_W-1:0]       w_rd_ext;
  logic [WORD_W-1:0]       w_rs_ext;

  assign w_opc    = r_ir[OPC_MSB:OPC_LSB];
  assign w_rd_ext = {{(WORD_W-3){1'b0}}, r_ir[RD_MSB:RD_LSB]};
  assign w_rs_ext = {{(WORD_W-3){1'b0}}, r_ir[RS_MSB:RS_LSB]};

  fd_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_pc_inc),
    .o_pc  (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FD_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Every ack-consuming state also drives w_req, so mem_ack is used directly.
  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_pc_inc = 1'b0;
    case (r_state)
      FD_FETCH: begin
        w_req = 1'b1;
        if (mem_ack) begin
          w_pc_inc = 1'b1;
          w_next   = FD_DECODE;
        end
      end
      FD_DECODE: begin
        w_next = is_two_word(w_opc) ? FD_IMM : FD_ISSUE;
      end
      FD_IMM: begin
        w_req = 1'b1;
        if (mem_ack) begin
          w_pc_inc = 1'b1;
          w_next   = (w_opc == OP_LDA) ? FD_OPND : FD_ISSUE;
        end
      end
      FD_OPND: begin
        w_req = 1'b1;
        if (mem_ack) begin
          w_next = FD_ISSUE;
        end
      end
      FD_ISSUE: begin
        if (dec_ready) begin
          w_next = FD_FETCH;
        end
      end
      default: begin
        w_next = FD_FETCH;
      end
    endcase
  end

  // Gating with rst_n drops the request the moment reset is asserted.
  assign mem_req   = w_req & rst_n;
  assign mem_addr  = (r_state == FD_OPND) ? r_imm : pc;
  assign dec_valid = (r_state == FD_ISSUE);
  assign rf_raddr1 = r_ir[RD_MSB:RD_LSB];
  assign rf_raddr2 = r_ir[RS_MSB:RS_LSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= '0;
      r_imm   <= '0;
      r_ldata <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
    end else begin
      case (r_state)
        FD_FETCH: begin
          if (mem_ack) r_ir <= mem_rdata[OPC_MSB:RS_LSB];
        end
        FD_DECODE: begin
          r_rd1 <= rf_rdata1;
          r_rd2 <= rf_rdata2;
        end
        FD_IMM: begin
          if (mem_ack) r_imm <= mem_rdata;
        end
        FD_OPND: begin
          if (mem_ack) r_ldata <= mem_rdata;
        end
        default: begin
        end
      endcase
    end
  end

  // The bundle is a pure function of registers frozen once ISSUE is reached.
  always_comb begin
    am_opcode   = w_opc;
    op1_data    = r_rd1;
    op2_data    = r_rd2;
    op1_regaddr = w_rd_ext;
    op2_regaddr = w_rs_ext;
    if (w_opc == OP_MVI) begin
      op2_data    = r_imm;
      op2_regaddr = r_imm;
    end else if (w_opc == OP_LDA) begin
      op1_data    = r_ldata;
      op2_data    = '0;
      op1_regaddr = r_imm;
      op2_regaddr = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode.sv
// ============================================================================
// Module   : tb_fetch_decode
// Purpose  : Self-checking bench for fetch_decode against a program-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_decode;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];
  int          waits = 0;
  logic        force_ack = 1'b0;
  int          wcnt;

  logic        mem_req, mem_ack, dec_valid, dec_ready;
  logic [15:0] mem_addr, mem_rdata, rf_rdata1, rf_rdata2;
  logic [15:0] op1_data, op2_data, op1_regaddr, op2_regaddr, pc;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [3:0]  am_opcode;

  logic        mem_req2, dec_valid2;
  logic [15:0] mem_addr2, mem_rdata2, rf_rdata1b, rf_rdata2b;
  logic [15:0] op1_data2, op2_data2, op1_regaddr2, op2_regaddr2, pc2;
  logic [2:0]  rf_raddr1b, rf_raddr2b;
  logic [3:0]  am_opcode2;

  fetch_decode #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .op1_data(op1_data), .op2_data(op2_data), .op1_regaddr(op1_regaddr),
    .op2_regaddr(op2_regaddr), .am_opcode(am_opcode), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .pc(pc)
  );

  // Second instance exercises the PC wrap from a reset value of FFFF.
  fetch_decode #(.RESET_PC(16'hFFFF)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_rdata(mem_rdata2), .mem_ack(mem_req2), .rf_raddr1(rf_raddr1b),
    .rf_raddr2(rf_raddr2b), .rf_rdata1(rf_rdata1b), .rf_rdata2(rf_rdata2b),
    .op1_data(op1_data2), .op2_data(op2_data2), .op1_regaddr(op1_regaddr2),
    .op2_regaddr(op2_regaddr2), .am_opcode(am_opcode2), .dec_valid(dec_valid2),
    .dec_ready(1'b0), .pc(pc2)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                          wcnt <= 0;
  end

  assign mem_ack    = (mem_req && (wcnt == waits)) || force_ack;
  assign mem_rdata  = mem[mem_addr];
  assign rf_rdata1  = rf[rf_raddr1];
  assign rf_rdata2  = rf[rf_raddr2];
  assign mem_rdata2 = mem[mem_addr2];
  assign rf_rdata1b = rf[rf_raddr1b];
  assign rf_rdata2b = rf[rf_raddr2b];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Program-level model: what one instruction at address p must yield.
  task automatic predict(input logic [15:0] p, output logic [3:0] e_op,
                         output logic [15:0] e1d, output logic [15:0] e2d,
                         output logic [15:0] e1a, output logic [15:0] e2a,
                         output logic [15:0] e_npc, output int e_lat);
    logic [15:0] w, p1, imm;
    int words;
    w    = mem[p];
    p1   = p + 16'd1;
    imm  = mem[p1];
    e_op = w[15:12];
    e1d  = rf[w[11:9]];
    e2d  = rf[w[8:6]];
    e1a  = {13'd0, w[11:9]};
    e2a  = {13'd0, w[8:6]};
    words = 1;
    if (e_op == OP_MVI) begin
      e2d = imm; e2a = imm; words = 2;
    end else if (e_op == OP_LDA) begin
      e1d = mem[imm]; e1a = imm; e2d = 16'h0; e2a = 16'h0; words = 3;
    end
    e_npc = p + 16'(words == 1 ? 1 : 2);
    e_lat = words * (waits + 1) + 2;
  endtask

  logic [15:0] m_pc;
  int          cyc, stall, hs_count = 0;
  logic [3:0]  x_op;
  logic [15:0] x1d, x2d, x1a, x2a, x_npc;
  int          x_lat;
  logic [3:0]  hs_op;
  logic [15:0] hs_d1, hs_d2, hs_a1, hs_a2, hs_pc;
  int          hs_lat;
  logic [15:0] ack_log[$];
  logic [15:0] ack_log2[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = 16'h0000; cyc = 0; stall = 0;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_pc", 32'(pc), 32'h0000);
    end else begin
      cyc++;
      if (mem_req && mem_ack) ack_log.push_back(mem_addr);
      if (mem_req2) ack_log2.push_back(mem_addr2);
      if (dec_valid) begin
        predict(m_pc, x_op, x1d, x2d, x1a, x2a, x_npc, x_lat);
        chk("am_opcode", 32'(am_opcode), 32'(x_op));
        chk("op1_data", 32'(op1_data), 32'(x1d));
        chk("op2_data", 32'(op2_data), 32'(x2d));
        chk("op1_regaddr", 32'(op1_regaddr), 32'(x1a));
        chk("op2_regaddr", 32'(op2_regaddr), 32'(x2a));
        chk("issue_pc", 32'(pc), 32'(x_npc));
        chk("issue_mem_req", 32'(mem_req), 32'd0);
        if (dec_ready) begin
          chk("latency", 32'(cyc), 32'(x_lat + stall));
          hs_op = am_opcode; hs_d1 = op1_data; hs_d2 = op2_data;
          hs_a1 = op1_regaddr; hs_a2 = op2_regaddr; hs_pc = pc; hs_lat = cyc;
          hs_count++;
          m_pc = x_npc; cyc = 0; stall = 0;
        end else begin
          stall++;
        end
      end
    end
  end

  task automatic assert_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask

  task automatic release_reset(input int w, input logic rdy);
    waits = w; dec_ready = rdy;
    repeat (2) @(posedge clk);
    #1;
    ack_log.delete(); ack_log2.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input string name);
    int start, k;
    start = hs_count; k = 0;
    while (hs_count == start && k < 200) begin
      @(posedge clk); k++;
    end
    chk(name, 32'(hs_count != start), 32'd1);
  endtask

  task automatic chk_hs(input string tag, input logic [3:0] op, input logic [15:0] d1,
                        input logic [15:0] a1, input logic [15:0] d2, input logic [15:0] a2,
                        input logic [15:0] npc, input int lat);
    chk({tag, "_op"}, 32'(hs_op), 32'(op));
    chk({tag, "_op1_data"}, 32'(hs_d1), 32'(d1));
    chk({tag, "_op1_regaddr"}, 32'(hs_a1), 32'(a1));
    chk({tag, "_op2_data"}, 32'(hs_d2), 32'(d2));
    chk({tag, "_op2_regaddr"}, 32'(hs_a2), 32'(a2));
    chk({tag, "_pc"}, 32'(hs_pc), 32'(npc));
    chk({tag, "_latency"}, 32'(hs_lat), 32'(lat));
  endtask

  logic [15:0] snap1, snap2;
  int          k;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rf[i] = {4{4'(i)}};
    dec_ready = 1'b1;

    // MOV at 0, then an "other" opcode; wrap instance runs MVI at FFFF.
    mem[16'h0000] = 16'hB280;
    mem[16'h0001] = 16'h3E40;
    mem[16'hFFFF] = 16'hC600;
    release_reset(0, 1'b1);
    wait_hs("hs_mov");
    chk_hs("mov", 4'hB, 16'h1111, 16'h0001, 16'h2222, 16'h0002, 16'h0001, 3);
    wait_hs("hs_other");
    k = 0;
    while (!dec_valid2 && k < 20) begin @(posedge clk); k++; end
    #1;
    chk("wrap_valid", 32'(dec_valid2), 32'd1);
    chk("wrap_op1_regaddr", 32'(op1_regaddr2), 32'h0003);
    chk("wrap_op1_data", 32'(op1_data2), 32'h3333);
    chk("wrap_op2_data", 32'(op2_data2), 32'hB280);
    chk("wrap_op2_regaddr", 32'(op2_regaddr2), 32'hB280);
    chk("wrap_pc", 32'(pc2), 32'h0001);
    chk("wrap_log_size", 32'(ack_log2.size() >= 2), 32'd1);
    if (ack_log2.size() >= 2) begin
      chk("wrap_addr0", 32'(ack_log2[0]), 32'hFFFF);
      chk("wrap_addr1", 32'(ack_log2[1]), 32'h0000);
    end

    // MVI with zero-wait memory.
    assert_reset();
    mem[16'h0000] = 16'hC600; mem[16'h0001] = 16'hBEEF; mem[16'h0002] = 16'h0000;
    release_reset(0, 1'b1);
    wait_hs("hs_mvi");
    chk_hs("mvi", 4'hC, 16'h3333, 16'h0003, 16'hBEEF, 16'hBEEF, 16'h0002, 4);

    // LDA with two wait states per access.
    assert_reset();
    mem[16'h0000] = 16'hD000; mem[16'h0001] = 16'h0040; mem[16'h0040] = 16'h1234;
    release_reset(2, 1'b1);
    wait_hs("hs_lda");
    chk_hs("lda", 4'hD, 16'h1234, 16'h0040, 16'h0000, 16'h0000, 16'h0002, 11);
    chk("lda_log_size", 32'(ack_log.size() >= 3), 32'd1);
    if (ack_log.size() >= 3) begin
      chk("lda_addr0", 32'(ack_log[0]), 32'h0000);
      chk("lda_addr1", 32'(ack_log[1]), 32'h0001);
      chk("lda_addr2", 32'(ack_log[2]), 32'h0040);
    end

    // Backpressure for 10 cycles, with a stray ack while no request is up.
    assert_reset();
    mem[16'h0000] = 16'hBA40; mem[16'h0001] = 16'h0000;
    release_reset(0, 1'b0);
    k = 0;
    while (!dec_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("bp_valid", 32'(dec_valid), 32'd1);
    snap1 = op1_data; snap2 = op2_regaddr;
    force_ack = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_op1_stable", 32'(op1_data), 32'(snap1));
      chk("bp_op2ra_stable", 32'(op2_regaddr), 32'(snap2));
      chk("bp_mem_req", 32'(mem_req), 32'd0);
      chk("bp_pc", 32'(pc), 32'h0001);
    end
    force_ack = 1'b0;
    dec_ready = 1'b1;
    wait_hs("hs_bp");
    chk_hs("bp", 4'hB, 16'h5555, 16'h0005, 16'h1111, 16'h0001, 16'h0001, 13);

    // Reset while the immediate fetch is waiting for its ack.
    assert_reset();
    mem[16'h0000] = 16'hC600; mem[16'h0001] = 16'hBEEF;
    release_reset(3, 1'b1);
    k = 0;
    while (!(pc == 16'h0001 && mem_req) && k < 50) begin @(posedge clk); #1; k++; end
    chk("mid_in_imm", 32'(pc == 16'h0001 && mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_mem_req", 32'(mem_req), 32'd0);
    chk("mid_pc", 32'(pc), 32'h0000);
    chk("mid_op1_data", 32'(op1_data), 32'h0000);
    chk("mid_am_opcode", 32'(am_opcode), 32'h0);
    chk("mid_dec_valid", 32'(dec_valid), 32'd0);
    chk("mid_rf_raddr1", 32'(rf_raddr1), 32'd0);
    release_reset(0, 1'b1);
    wait_hs("hs_after_reset");
    chk_hs("rerun", 4'hC, 16'h3333, 16'h0003, 16'hBEEF, 16'hBEEF, 16'h0002, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
